// File: rtl/cpu_control_unit.sv
// Moore control sequencer for ALUSystem: two-byte fetch, decode, one or two execute steps.
// Latency: 4 cycles per instruction, 5 for direct LD and ST; no backpressure, outputs decode State/IROut/Z.
module cpu_control_unit #(
   parameter bit         CLEAR_ON_RESET = 1'b1,
   parameter logic [3:0] HALT_OPCODE    = 4'hF
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IROut,
   input  logic        Z,
   output logic [1:0]  RF_OutASel,
   output logic [1:0]  RF_OutBSel,
   output logic [1:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  ALU_FunSel,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [1:0]  ARF_FunSel,
   output logic [2:0]  ARF_RegSel,
   output logic        IR_LH,
   output logic        IR_Enable,
   output logic [1:0]  IR_Funsel,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic [2:0]  State,
   output logic        Halted
);

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_FL   = 3'd1,
      S_FH   = 3'd2,
      S_DEC  = 3'd3,
      S_EX1  = 3'd4,
      S_EX2  = 3'd5,
      S_HALT = 3'd6
   } state_t;

   localparam logic [3:0] OP_LD  = 4'd0;
   localparam logic [3:0] OP_ST  = 4'd1;
   localparam logic [3:0] OP_MOV = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_INC = 4'd5;
   localparam logic [3:0] OP_DEC = 4'd6;
   localparam logic [3:0] OP_BRA = 4'd7;
   localparam logic [3:0] OP_BNE = 4'd8;

   localparam logic [1:0] FUN_DEC   = 2'b00;
   localparam logic [1:0] FUN_INC   = 2'b01;
   localparam logic [1:0] FUN_LOAD  = 2'b10;
   localparam logic [1:0] FUN_CLEAR = 2'b11;

   state_t state, state_nxt;

   logic [3:0] op;
   logic       am;
   logic [1:0] rsel, dst, src1, src2;
   logic       is_halt, two_step;
   logic       unused_ir;

   assign op        = IROut[15:12];
   assign am        = IROut[10];
   assign rsel      = IROut[9:8];
   assign dst       = IROut[11:10];
   assign src1      = IROut[9:8];
   assign src2      = IROut[7:6];
   // The low operand bits reach the datapath through the muxes, never through control.
   assign unused_ir = ^IROut[5:0];

   // Halt decode wins even if HALT_OPCODE collides with a defined opcode.
   assign is_halt  = (op == HALT_OPCODE);
   assign two_step = !is_halt && ((op == OP_LD && !am) || op == OP_ST);

   function automatic logic [3:0] reg_mask(input logic [1:0] n);
      return ~(4'b1000 >> n);
   endfunction

   always_ff @(posedge Clock) begin
      if (Reset) state <= S_INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_INIT;
      case (state)
         S_INIT: state_nxt = S_FL;
         S_FL:   state_nxt = S_FH;
         S_FH:   state_nxt = S_DEC;
         S_DEC:  state_nxt = S_EX1;
         S_EX1:  state_nxt = is_halt ? S_HALT : (two_step ? S_EX2 : S_FL);
         S_EX2:  state_nxt = S_FL;
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      RF_OutASel  = 2'b00;
      RF_OutBSel  = 2'b00;
      RF_FunSel   = 2'b00;
      RF_RegSel   = 4'b1111;
      ALU_FunSel  = 4'b0000;
      ARF_OutCSel = 2'b00;
      ARF_OutDSel = 2'b00;
      ARF_FunSel  = 2'b00;
      ARF_RegSel  = 3'b111;
      IR_LH       = 1'b0;
      IR_Enable   = 1'b0;
      IR_Funsel   = 2'b00;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 1'b0;
      Halted      = 1'b0;

      case (state)
         S_INIT: begin
            if (CLEAR_ON_RESET) begin
               RF_RegSel  = 4'b0000;
               RF_FunSel  = FUN_CLEAR;
               ARF_RegSel = 3'b000;
               ARF_FunSel = FUN_CLEAR;
            end
         end
         S_FL, S_FH: begin
            // Byte read at PC into the IR half, PC++ on the same edge.
            ARF_OutDSel = 2'b00;
            Mem_CS      = 1'b0;
            IR_Enable   = 1'b1;
            IR_Funsel   = FUN_LOAD;
            IR_LH       = (state == S_FH);
            ARF_RegSel  = 3'b011;
            ARF_FunSel  = FUN_INC;
         end
         S_EX1: begin
            if (!is_halt) begin
               case (op)
                  OP_LD, OP_ST: begin
                     if (op == OP_LD && am) begin
                        MuxASel   = 2'b10;
                        RF_FunSel = FUN_LOAD;
                        RF_RegSel = reg_mask(rsel);
                     end else begin
                        MuxBSel    = 2'b10;
                        ARF_RegSel = 3'b101;
                        ARF_FunSel = FUN_LOAD;
                     end
                  end
                  OP_MOV, OP_ADD, OP_SUB: begin
                     RF_OutASel = src1;
                     RF_OutBSel = (op == OP_MOV) ? 2'b00 : src2;
                     MuxCSel    = 1'b0;
                     ALU_FunSel = (op == OP_MOV) ? 4'b0000 :
                                  (op == OP_ADD) ? 4'b0100 : 4'b0110;
                     MuxASel    = 2'b00;
                     RF_FunSel  = FUN_LOAD;
                     RF_RegSel  = reg_mask(dst);
                  end
                  OP_INC, OP_DEC: begin
                     RF_FunSel = (op == OP_INC) ? FUN_INC : FUN_DEC;
                     RF_RegSel = reg_mask(dst);
                  end
                  OP_BRA, OP_BNE: begin
                     if (op == OP_BRA || !Z) begin
                        MuxBSel    = 2'b10;
                        ARF_RegSel = 3'b011;
                        ARF_FunSel = FUN_LOAD;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_EX2: begin
            // Memory access through AR, loaded in EX1.
            ARF_OutDSel = 2'b01;
            Mem_CS      = 1'b0;
            if (op == OP_ST) begin
               Mem_WR     = 1'b1;
               RF_OutASel = rsel;
               MuxCSel    = 1'b0;
               ALU_FunSel = 4'b0000;
            end else begin
               MuxASel   = 2'b01;
               RF_FunSel = FUN_LOAD;
               RF_RegSel = reg_mask(rsel);
            end
         end
         S_HALT: Halted = 1'b1;
         default: ;
      endcase
   end

   assign State = state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed and random instructions against an instruction-level model.
module tb_cpu_control_unit;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] IROut = 16'h0000;
   logic        Z = 1'b0;
   logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
   logic [3:0]  RF_RegSel, ALU_FunSel;
   logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
   logic [2:0]  ARF_RegSel;
   logic        IR_LH, IR_Enable;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR, Mem_CS;
   logic [1:0]  MuxASel, MuxBSel;
   logic        MuxCSel;
   logic [2:0]  State;
   logic        Halted;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [1:0] rf_outa;
      logic [1:0] rf_outb;
      logic [1:0] rf_fun;
      logic [3:0] rf_reg;
      logic [3:0] alu_fun;
      logic [1:0] arf_outc;
      logic [1:0] arf_outd;
      logic [1:0] arf_fun;
      logic [2:0] arf_reg;
      logic       ir_lh;
      logic       ir_en;
      logic [1:0] ir_fun;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_a;
      logic [1:0] mux_b;
      logic       mux_c;
      logic       halted;
   } ctl_t;

   ctl_t act;

   cpu_control_unit dut (
      .Clock(Clock), .Reset(Reset), .IROut(IROut), .Z(Z),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
      .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel),
      .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
      .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
      .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
      .MuxCSel(MuxCSel), .State(State), .Halted(Halted)
   );

   assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
                 ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable,
                 IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted};

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge Clock);
      #1;
   endtask

   // Register n is written through the one-hot-low mask whose set bit is 3-n.
   function automatic logic [3:0] mask(input logic [1:0] n);
      return 4'(15 - (1 << (3 - int'(n))));
   endfunction

   function automatic ctl_t idle_ctl;
      ctl_t c = '0;
      c.rf_reg  = 4'hF;
      c.arf_reg = 3'h7;
      c.mem_cs  = 1'b1;
      return c;
   endfunction

   function automatic ctl_t fetch_ctl(input logic high);
      ctl_t c = idle_ctl();
      c.mem_cs  = 1'b0;
      c.ir_en   = 1'b1;
      c.ir_fun  = 2'b10;
      c.ir_lh   = high;
      c.arf_reg = 3'b011;
      c.arf_fun = 2'b01;
      return c;
   endfunction

   function automatic bit needs_ex2(input logic [15:0] ir);
      return (ir[15:12] == 4'd1) || (ir[15:12] == 4'd0 && !ir[10]);
   endfunction

   // What the datapath must do in the first execute cycle of instruction ir.
   function automatic ctl_t ex1_ctl(input logic [15:0] ir, input logic z);
      ctl_t c = idle_ctl();
      int   op = int'(ir[15:12]);
      if (needs_ex2(ir)) begin
         c.mux_b = 2'b10; c.arf_reg = 3'b101; c.arf_fun = 2'b10;
      end else if (op == 0) begin
         c.mux_a = 2'b10; c.rf_fun = 2'b10; c.rf_reg = mask(ir[9:8]);
      end else if (op >= 2 && op <= 4) begin
         c.rf_outa = ir[9:8];
         c.rf_outb = (op == 2) ? 2'b00 : ir[7:6];
         c.alu_fun = (op == 2) ? 4'd0 : (op == 3) ? 4'd4 : 4'd6;
         c.rf_fun  = 2'b10;
         c.rf_reg  = mask(ir[11:10]);
      end else if (op == 5 || op == 6) begin
         c.rf_fun = (op == 5) ? 2'b01 : 2'b00;
         c.rf_reg = mask(ir[11:10]);
      end else if (op == 7 || (op == 8 && !z)) begin
         c.mux_b = 2'b10; c.arf_reg = 3'b011; c.arf_fun = 2'b10;
      end
      return c;
   endfunction

   function automatic ctl_t ex2_ctl(input logic [15:0] ir);
      ctl_t c = idle_ctl();
      c.arf_outd = 2'b01;
      c.mem_cs   = 1'b0;
      if (ir[15:12] == 4'd1) begin
         c.mem_wr  = 1'b1;
         c.rf_outa = ir[9:8];
      end else begin
         c.mux_a  = 2'b01;
         c.rf_fun = 2'b10;
         c.rf_reg = mask(ir[9:8]);
      end
      return c;
   endfunction

   // Entered just after the edge into FL; leaves just after the edge that ends the instruction.
   task automatic exec(input logic [15:0] ir, input logic z, input bit reset_in_ex2);
      @(negedge Clock);
      check("fl_state", 64'(State), 64'd1);
      check("fl_ctl", 64'(act), 64'(fetch_ctl(1'b0)));
      step;
      IROut = ir;
      Z     = z;
      @(negedge Clock);
      check("fh_state", 64'(State), 64'd2);
      check("fh_ctl", 64'(act), 64'(fetch_ctl(1'b1)));
      step;
      @(negedge Clock);
      check("dec_state", 64'(State), 64'd3);
      check("dec_ctl", 64'(act), 64'(idle_ctl()));
      step;
      @(negedge Clock);
      check("ex1_state", 64'(State), 64'd4);
      check("ex1_ctl", 64'(act), 64'(ex1_ctl(ir, z)));
      if (needs_ex2(ir) && ir[15:12] != 4'hF) begin
         step;
         @(negedge Clock);
         check("ex2_state", 64'(State), 64'd5);
         check("ex2_ctl", 64'(act), 64'(ex2_ctl(ir)));
         if (reset_in_ex2) begin
            Reset = 1'b1;
            step;
            @(negedge Clock);
            check("rst_ex2_state", 64'(State), 64'd0);
            check("rst_ex2_memwr", 64'(Mem_WR), 64'd0);
         end
      end
      step;
   endtask

   task automatic release_reset;
      @(negedge Clock);
      check("init_state", 64'(State), 64'd0);
      check("init_ctl", 64'(act), 64'({4'b0, 2'b11, 4'b0000, 4'b0, 2'b0, 2'b0, 2'b11, 3'b000,
                                       1'b0, 1'b0, 2'b0, 1'b0, 1'b1, 2'b0, 2'b0, 1'b0, 1'b0}));
      step;
      Reset = 1'b0;
      @(negedge Clock);
      check("init_hold_state", 64'(State), 64'd0);
      step;
   endtask

   initial begin
      logic [15:0] ir;
      repeat (3) step;
      release_reset;

      exec(16'h0512, 1'b0, 1'b0);
      exec(16'h1140, 1'b0, 1'b0);
      exec(16'h8020, 1'b1, 1'b0);
      exec(16'h8020, 1'b0, 1'b0);
      exec(16'h3E40, 1'b0, 1'b0);
      exec(16'h0140, 1'b1, 1'b0);
      exec(16'h7055, 1'b1, 1'b0);

      for (int i = 0; i < 60; i++) begin
         ir = 16'($urandom);
         if (ir[15:12] == 4'hF) ir[15:12] = 4'hE;
         exec(ir, 1'($urandom_range(0, 1)), 1'b0);
      end

      exec(16'hF000, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge Clock);
         check("halt_state", 64'(State), 64'd6);
         check("halt_flag", 64'(Halted), 64'd1);
         step;
      end
      Reset = 1'b1;
      step;
      release_reset;

      exec(16'h1240, 1'b0, 1'b1);
      step;
      release_reset;
      exec(16'h0512, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Hardwired, Moore-style control sequencer for the ALUSystem datapath (RF, ARF, IR, ALU, memory, MuxA/B/C). It drives every ALUSystem control input: it fetches each 16-bit instruction as two byte reads into the IR, decodes `IROut`, and issues one or two execute micro-steps before returning to fetch. It is the stage directly upstream of ALUSystem and replaces the test-vector source currently used to exercise it.

## Interface
- `CLEAR_ON_RESET`, default 1: 1 = INIT clears all RF and ARF registers; 0 = INIT is idle.
- `HALT_OPCODE`, default 4'hF: opcode that enters HALT.

- `Clock` in 1: single clock, all state updates on rising edge.
- `Reset` in 1: synchronous, active-high.
- `IROut` in 16: ALUSystem IR output.
- `Z` in 1: ALUSystem `ALUOutFlag[3]`.
- `RF_OutASel`, `RF_OutBSel`, `RF_FunSel` out 2 each.
- `RF_RegSel` out 4: active-low; bit3 = R1 … bit0 = R4.
- `ALU_FunSel` out 4.
- `ARF_OutCSel`, `ARF_OutDSel`, `ARF_FunSel` out 2 each.
- `ARF_RegSel` out 3: active-low; bit2 = PC, bit1 = AR, bit0 = SP.
- `IR_LH` out 1, `IR_Enable` out 1, `IR_Funsel` out 2.
- `Mem_WR` out 1, `Mem_CS` out 1 (active-low).
- `MuxASel` out 2, `MuxBSel` out 2, `MuxCSel` out 1.
- `State` out 3: current state, exported for verification.
- `Halted` out 1: high in HALT.

## Operation
- **Encodings:**
  - FunSel: 00 dec, 01 inc, 10 load, 11 clear.
  - ARF OutD/OutC selects: 00 PC, 01 AR.
  - MuxA (RF input): 00 ALUOut, 01 MemOut, 10 IR[7:0], 11 ARF COut.
  - MuxB (ARF input): 00 ALUOut, 01 MemOut, 10 IR[7:0].
  - MuxC: 0 = RF AOut to ALU A.
  - ALU: 0000 pass A, 0100 A+B, 0110 A−B.
  - Mem_WR: 0 read.
- **IDLE pattern** (every output not listed for a state): RF_RegSel=1111, ARF_RegSel=111, IR_Enable=0, Mem_CS=1, Mem_WR=0, all other selects 0.
- **States:** INIT=0, FL=1, FH=2, DEC=3, EX1=4, EX2=5, HALT=6.
- **INIT:**
  - With CLEAR_ON_RESET=1: RF_RegSel=0000, RF_FunSel=11, ARF_RegSel=000, ARF_FunSel=11.
  - Next state: FL.
- **FL:** ARF_OutDSel=00, Mem_CS=0, IR_Enable=1, IR_Funsel=10, IR_LH=0, ARF_RegSel=011, ARF_FunSel=01 (PC++). Next state: FH.
- **FH:** same as FL but IR_LH=1. Next state: DEC.
- **DEC:** IDLE outputs. Next state: EX1.
- **Instruction fields:**
  - op = IR[15:12].
  - Memory-reference format: AM = IR[10] (1 = immediate), RSel = IR[9:8], operand = IR[7:0].
  - Register format: DST = IR[11:10], SRC1 = IR[9:8], SRC2 = IR[7:6].
  - Register n selects RF_RegSel = ~(4'b1000 >> n) and OutASel/OutBSel = n.
- **Opcodes in EX1:**
  - 0 LD:
    - AM=1: MuxASel=10, RF load RSel; then FL.
    - AM=0: MuxBSel=10, ARF load AR (ARF_RegSel=101, FunSel=10); then EX2.
  - 1 ST: load AR as for direct LD; then EX2.
  - 2 MOV: OutASel=SRC1, MuxCSel=0, ALU 0000, MuxASel=00, RF load DST.
  - 3 ADD / 4 SUB: OutASel=SRC1, OutBSel=SRC2, ALU 0100 / 0110, MuxASel=00, RF load DST.
  - 5 INC / 6 DEC: RF_FunSel=01 / 00 on DST.
  - 7 BRA: MuxBSel=10, ARF load PC (ARF_RegSel=011).
  - 8 BNE: same as BRA if Z=0, otherwise IDLE.
  - HALT_OPCODE: IDLE, then HALT.
  - Any other opcode: IDLE (NOP).
  - Unless stated otherwise, EX1 goes to FL.
- **EX2:**
  - ARF_OutDSel=01, Mem_CS=0.
  - LD: MuxASel=01, RF load RSel.
  - ST: Mem_WR=1, OutASel=RSel, MuxCSel=0, ALU 0000.
  - Next state: FL.
- **HALT:** IDLE, Halted=1. Stays in HALT until Reset.
- **Reset:** a rising edge with Reset=1 forces State=INIT from any state, including mid-fetch or EX2. Reset held high keeps INIT.

## Timing
- All outputs are a pure decode of `State`, `IROut` and `Z`. No output register.
- Memory reads are asynchronous, so the IR, RF and ARF capture data on the same edge that ends the state.
- Per-instruction latency:
  - 4 cycles (FL, FH, DEC, EX1) for single-step opcodes.
  - 5 cycles for direct LD and for ST.
- After Reset deasserts: INIT for 1 cycle, then FL.
- `IROut` must stay stable from DEC through EX2; only FL and FH write the IR.
- `Z` is sampled combinationally during EX1 of BNE. It reflects the flags latched by the most recent ALU operation.
- BRA/BNE taken: PC = IR[7:0] after EX1. The PC++ from FH is overwritten.

## Test plan
- Reset 3 cycles, release:
  - State 0 then 1.
  - In INIT: RF_RegSel=0000, ARF_RegSel=000, both FunSel=11.
  - In FL: ARF_RegSel=011, IR_LH=0, Mem_CS=0.
- IROut=16'h0512 (LD imm R2 ← 0x12) held from DEC:
  - EX1 drives MuxASel=10, RF_FunSel=10, RF_RegSel=1011.
  - Next State=1; total 4 cycles.
- IROut=16'h1140 (ST R2 → [0x40]):
  - EX1: ARF_RegSel=101, MuxBSel=10.
  - EX2: Mem_WR=1, Mem_CS=0, ARF_OutDSel=01, RF_OutASel=01.
- IROut=16'h8020 with Z=1 → EX1 IDLE (ARF_RegSel=111). Repeat with Z=0 → ARF_RegSel=011, MuxBSel=10.
- IROut=16'h3E40 (ADD R4 ← R3+R2): RF_OutASel=10, RF_OutBSel=01, ALU_FunSel=0100, RF_RegSel=1110.
- IROut=16'hF000:
  - State reaches 6, Halted=1, stays for 20 cycles.
  - Reset asserted during EX2 of a ST on another run → next State=0, Mem_WR=0.
